// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the instruction memory write port
//
// Purpose: accepts a frame {LEN_LO, LEN_HI, N*4 payload bytes, XOR checksum}
// over a valid/ready byte handshake, packs payload bytes little-endian into
// 32-bit words, and writes them to consecutive word addresses from BASE_ADDR.
// CpuHold stays high until a frame completes with a matching checksum.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   Start                begin a load (honoured in IDLE, DONE, ERROR)
//   ByteIn, ByteValid    stream byte and its valid
//   ByteReady            registered ready; a byte moves on ByteValid & ByteReady
//   WrEn, WrAddr, WrData imem write strobe (one cycle per word), byte address, word
//   WordCount            words written in the current/last load
//   CpuHold              1 = keep the CPU stalled
//   Done, Error          sticky load result flags
module imem_loader #(
  parameter int          DEPTH_WORDS = 37,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic [15:0] WordCount,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  lane;
  logic [23:0] byte_buf;
  logic [7:0]  csum;
  logic        xfer;
  logic        start_ok;
  logic        last_word;

  assign xfer      = ByteValid & ByteReady;
  assign start_ok  = Start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign len_full  = {ByteIn, len_lo};
  assign last_word = (WordCount + 16'd1) == len;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (Start) next_state = S_LEN_LO;
      S_LEN_LO: if (xfer) next_state = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
        if (len_full == 16'd0 || len_full > DEPTH16) next_state = S_ERROR;
        else                                         next_state = S_DATA;
      end
      // Leave DATA on the edge that takes the last payload byte, so the
      // final write strobe overlaps the first CHECK cycle.
      S_DATA:   if (xfer && lane == 2'd3 && last_word) next_state = S_CHECK;
      S_CHECK:  if (xfer) next_state = (ByteIn == csum) ? S_DONE : S_ERROR;
      S_DONE:   if (Start) next_state = S_LEN_LO;
      S_ERROR:  if (Start) next_state = S_LEN_LO;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ByteReady <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= 32'h0;
      WrData    <= 32'h0;
      WordCount <= 16'd0;
      CpuHold   <= 1'b1;
      Done      <= 1'b0;
      Error     <= 1'b0;
      len_lo    <= 8'h0;
      len       <= 16'd0;
      lane      <= 2'd0;
      byte_buf  <= 24'h0;
      csum      <= 8'h0;
    end else begin
      state <= next_state;
      // Status outputs are decoded from the next state so they change
      // together with the state register.
      ByteReady <= (next_state == S_LEN_LO) | (next_state == S_LEN_HI) |
                   (next_state == S_DATA)   | (next_state == S_CHECK);
      Done      <= (next_state == S_DONE);
      Error     <= (next_state == S_ERROR);
      CpuHold   <= (next_state != S_DONE);
      WrEn      <= 1'b0;

      if (start_ok) begin
        csum      <= 8'h0;
        WordCount <= 16'd0;
        lane      <= 2'd0;
      end

      case (state)
        S_LEN_LO: if (xfer) len_lo <= ByteIn;
        S_LEN_HI: if (xfer) begin
          len  <= len_full;
          lane <= 2'd0;
        end
        S_DATA: if (xfer) begin
          csum <= csum ^ ByteIn;
          lane <= lane + 2'd1;
          case (lane)
            2'd0: byte_buf[7:0]   <= ByteIn;
            2'd1: byte_buf[15:8]  <= ByteIn;
            2'd2: byte_buf[23:16] <= ByteIn;
            default: begin
              WrEn      <= 1'b1;
              WrData    <= {ByteIn, byte_buf};
              WrAddr    <= BASE_ADDR + {14'b0, WordCount, 2'b00};
              WordCount <= WordCount + 16'd1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
